timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped 32-bit down-counting timer on the data-memory bus, downstream of the CPU core's load/store path. The core's store path drives its address, write-enable and write-data inputs. Its read-data output returns to the core's load mux. It counts down from a programmed preset, raises an interrupt request at zero, and supports one-shot and auto-reload modes.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — single system clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high; clears all state on a rising edge of `clk` while high.
- `A`  in  32  — byte address. Only `A[3:2]` is decoded: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `WE`  in  1  — write strobe from the core's store path.
- `WD`  in  32  — write data.
- `RD`  out  32  — read data, combinational from `A[3:2]`.
- `IRQ`  out  1  — interrupt request, registered-state derived.

## Operation
- CTRL bit fields:
  - [0] `EN`: enable.
  - [2:1] `MODE`: 00 = one-shot, 01 = periodic; 1x is treated as 00.
  - [3] `IM`: interrupt mask.
  - [31:4] read as 0.
- PRESET: 32-bit, read/write.
- COUNT: 32-bit, read-only; writes to it are ignored.
- Writes: `WE`=1 at address 0 loads CTRL[3:0] from `WD[3:0]`. Address 1 loads PRESET from `WD`. Addresses 2 and 3 are no-ops.
- A CTRL write also clears `irq_flag`.
- Reads: 0 → {28'b0, CTRL[3:0]}; 1 → PRESET; 2 → COUNT; 3 → 32'h0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if `EN`, go to LOAD; else stay.
  - LOAD: COUNT ← PRESET; go to CNT unconditionally.
  - CNT:
    - if !`EN`, go to IDLE, COUNT holds;
    - else if COUNT == 0, go to INT;
    - else COUNT ← COUNT − 1.
  - INT, one-shot:
    - hardware clears CTRL.EN;
    - sets `irq_flag`;
    - goes to IDLE.
  - INT, periodic:
    - go to LOAD;
    - `irq_flag` is not used.
- `IRQ` = `IM` & (one-shot ? `irq_flag` : state == INT).
  - One-shot IRQ is level, held until the next CTRL write.
  - Periodic IRQ is a one-cycle pulse per expiry.
- Decrement is unsigned 32-bit; COUNT never wraps below 0, because 0 is intercepted in CNT.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, `irq_flag` = 0, `IRQ` = 0. `RD` = 0 for any address.
- Reference sequence, PRESET = N, CTRL write `EN`=1 at edge e0:
  - e1: enter LOAD.
  - e2: COUNT = N, enter CNT.
  - e3..e(2+N): COUNT decrements, reaching 0 after e(2+N).
  - e(3+N): enter INT; `IRQ` is high after this edge.
  - e(4+N): enter IDLE (one-shot) or LOAD (periodic).
- Periodic reload period: N+3 cycles per IRQ pulse.
- PRESET = 0: INT is reached at e3.
- Simultaneous events:
  - CPU CTRL write in the INT cycle beats the hardware EN clear; CPU data is stored.
  - The CTRL write also wins over `irq_flag` set, so the flag ends at 0.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - A write is visible on `RD` the cycle after its edge.
- Clearing `EN` during CNT: freeze at the next edge, go to IDLE, COUNT holds its value. Re-enabling reloads from PRESET; there is no resume.
- `reset` asserted mid-count forces all reset values at that edge, including dropping `IRQ` the same edge.

## Test plan
- Reset, then read addresses 0/1/2/3 → all 32'h0; `IRQ`=0.
- PRESET=5, CTRL=4'b1001 (one-shot, IM=1, EN=1) at e0 → COUNT reads 5,4,3,2,1,0 after e2..e7. `IRQ` rises after e8 and stays high. CTRL reads 4'b1000.
- Repeat with a CTRL write of 0 → `IRQ` low the cycle after that write.
- PRESET=2, CTRL=4'b1011 (periodic, IM=1, EN=1) → `IRQ` is a one-cycle pulse every 5 cycles, first after e5; at least 3 pulses checked.
- One-shot with IM=0 → `IRQ` stays 0 throughout.
- During CNT with COUNT=3, write CTRL EN=0 → COUNT frozen at 2 and state IDLE.
- Mid-count: write PRESET=9 → current count is unaffected; the next enable loads 9.
- With COUNT=4, assert `reset` → all reads 0 next cycle and `IRQ`=0.
- Write to address 2 → COUNT unchanged.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and periodic modes.
// Latency: register writes visible on RD the cycle after the edge; RD is combinational from A[3:2].
// Backpressure: none; every bus write completes in its own cycle, reads never stall.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_en;
    logic        w_periodic;
    logic        w_im;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_in_int;
    logic        w_unused_a;

    // Only A[3:2] selects a register; the remaining address bits are don't-care.
    assign w_unused_a = &{1'b0, A[31:4], A[1:0]};

    assign w_en        = r_ctrl[0];
    // MODE 1x falls back to one-shot, so only the exact 01 encoding is periodic.
    assign w_periodic  = (r_ctrl[2:1] == 2'b01);
    assign w_im        = r_ctrl[3];
    assign w_wr_ctrl   = WE && (A[3:2] == ADDR_CTRL);
    assign w_wr_preset = WE && (A[3:2] == ADDR_PRESET);
    assign w_in_int    = (r_state == S_INT);

    // CTRL register: CPU write has priority over the hardware EN clear at one-shot expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 4'h0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= WD[3:0];
        end else if (w_in_int && !w_periodic) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    // PRESET register: only sampled into COUNT in LOAD, so mid-count writes wait for the next reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_preset <= 32'h0;
        end else if (w_wr_preset) begin
            r_preset <= WD;
        end
    end

    // Sticky one-shot interrupt flag: set at expiry, cleared by any CTRL write (write wins a tie).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_irq_flag <= 1'b0;
        end else if (w_in_int && !w_periodic) begin
            r_irq_flag <= 1'b1;
        end
    end

    // Counter FSM: IDLE -> LOAD -> CNT -> INT, then IDLE (one-shot) or LOAD (periodic).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_en) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!w_en) begin
                        // Freeze: COUNT holds, a later enable reloads rather than resumes.
                        r_state <= S_IDLE;
                    end else if (r_count == 32'h0) begin
                        r_state <= S_INT;
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                S_INT: begin
                    r_state <= w_periodic ? S_LOAD : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read mux back to the core's load path.
    always_comb begin
        RD = 32'h0;
        case (A[3:2])
            ADDR_CTRL:   RD = {28'h0, r_ctrl};
            ADDR_PRESET: RD = r_preset;
            ADDR_COUNT:  RD = r_count;
            default:     RD = 32'h0;
        endcase
    end

    // Interrupt: one-shot asserts from the INT cycle onward and is then held by the sticky flag;
    // periodic is a single-cycle pulse while in INT.
    always_comb begin
        IRQ = w_im && (w_in_int || (!w_periodic && r_irq_flag));
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each check is an immediate assertion that counts and reports failures.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int checks;
    int failures;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .WE    (WE),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
        A  = {28'h0, idx, 2'b00};
        WD = data;
        WE = 1'b1;
        tick();
        WE = 1'b0;
        WD = 32'h0;
    endtask

    task automatic chk_rd(input string name, input logic [1:0] idx, input logic [31:0] exp);
        A = {28'h0, idx, 2'b00};
        #1;
        chk(name, RD, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        chk(name, {31'h0, IRQ}, {31'h0, exp});
    endtask

    task automatic chk_all_zero(input string name);
        for (int i = 0; i < 4; i++) begin
            chk_rd($sformatf("%s_rd%0d", name, i), i[1:0], 32'h0);
        end
        chk_irq({name, "_irq"}, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        A        = 32'h0;
        WE       = 1'b0;
        WD       = 32'h0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset");

        // One-shot, PRESET=5, IM=1
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);          // e0
        chk_rd("os_count_e0", 2'd2, 32'd0);
        tick();                           // e1: LOAD
        chk_rd("os_count_e1", 2'd2, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();                       // e2..e7
            chk_rd($sformatf("os_count_e%0d", k + 2), 2'd2, 32'(5 - k));
            chk_irq($sformatf("os_irq_e%0d", k + 2), 1'b0);
        end
        tick();                           // e8: INT
        chk_irq("os_irq_e8", 1'b1);
        tick();                           // e9: IDLE, flag set, EN cleared
        chk_irq("os_irq_e9", 1'b1);
        chk_rd("os_ctrl_after", 2'd0, 32'h8);
        tick();
        tick();
        chk_irq("os_irq_held", 1'b1);
        chk_rd("os_count_held", 2'd2, 32'd0);

        // CTRL write clears the level IRQ
        bus_write(2'd0, 32'h0);
        chk_irq("os_irq_cleared", 1'b0);

        // Periodic, PRESET=2: pulse after e5, e10, e15
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);          // e0
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk_irq($sformatf("per_irq_e%0d", c), (c % 5) == 0);
        end
        bus_write(2'd0, 32'h0);
        tick();
        tick();
        chk_irq("per_stopped", 1'b0);

        // One-shot with IM=0: IRQ never asserts
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk_irq($sformatf("mask_irq_e%0d", c), 1'b0);
        end
        chk_rd("mask_ctrl_en_cleared", 2'd0, 32'h0);

        // Freeze: disable during CNT at COUNT=3
        bus_write(2'd1, 32'd6);
        bus_write(2'd0, 32'h1);          // e0
        for (int c = 1; c <= 5; c++) tick();
        chk_rd("frz_count3", 2'd2, 32'd3);
        bus_write(2'd0, 32'h0);          // last decrement lands on this edge
        chk_rd("frz_count2", 2'd2, 32'd2);
        tick();
        chk_rd("frz_hold1", 2'd2, 32'd2);
        tick();
        chk_rd("frz_hold2", 2'd2, 32'd2);

        // Re-enable reloads from PRESET (no resume); mid-count PRESET write is deferred
        bus_write(2'd0, 32'h1);          // e0
        tick();                           // e1
        chk_rd("reload_e1", 2'd2, 32'd2);
        tick();                           // e2
        chk_rd("reload_e2", 2'd2, 32'd6);
        tick();                           // e3
        bus_write(2'd1, 32'd9);          // e4
        chk_rd("pre_mid_e4", 2'd2, 32'd4);
        tick();                           // e5
        chk_rd("pre_mid_e5", 2'd2, 32'd3);
        chk_rd("pre_readback", 2'd1, 32'd9);
        bus_write(2'd0, 32'h0);
        tick();
        bus_write(2'd0, 32'h1);          // e0
        tick();                           // e1
        tick();                           // e2
        chk_rd("pre_new_load", 2'd2, 32'd9);

        // Write to COUNT is ignored
        bus_write(2'd2, 32'd123);        // e3
        chk_rd("cnt_wr_ignored", 2'd2, 32'd8);
        for (int c = 0; c < 4; c++) tick();
        chk_rd("cnt_at4", 2'd2, 32'd4);

        // Reset mid-count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("mid_reset");
        bus_write(2'd2, 32'd55);
        chk_rd("cnt_wr_idle", 2'd2, 32'd0);

        // PRESET=0 reaches INT at e3; CTRL write in INT beats the HW clear and the flag set
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);          // e0
        tick();                           // e1
        tick();                           // e2
        chk_irq("p0_irq_e2", 1'b0);
        tick();                           // e3
        chk_irq("p0_irq_e3", 1'b1);
        bus_write(2'd0, 32'hF);          // e4, in INT
        chk_rd("int_wr_ctrl", 2'd0, 32'hF);
        chk_irq("int_wr_irq", 1'b0);
        tick();                           // LOAD
        tick();                           // CNT
        tick();                           // INT, MODE=11 acts as one-shot
        chk_irq("mode11_irq", 1'b1);
        tick();
        chk_rd("mode11_en_clr", 2'd0, 32'hE);
        chk_irq("mode11_held", 1'b1);

        // Reset drops a held IRQ at the same edge
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("irq_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
